// File: rtl/reg_dump_pkg.sv
// +----------------------------------------------------------------------+
// | reg_dump_pkg : shared types and constants for reg_dump_sequencer     |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
`default_nettype none

package reg_dump_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    SHOW = 2'd2
  } dump_state_t;

  // Active-low segments, bit order gfedcba
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

endpackage

`default_nettype wire

// File: rtl/hex_to_seg7.sv
// +----------------------------------------------------------------------+
// | hex_to_seg7 : 4-bit hex digit to active-low 7-segment (gfedcba)      |
// | Revision    : 1.0                                                     |
// +----------------------------------------------------------------------+
`default_nettype none

module hex_to_seg7
  import reg_dump_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (hex)
      4'h0: seg = SEG_ZERO;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/reg_dump_sequencer.sv
// +----------------------------------------------------------------------+
// | reg_dump_sequencer : sweeps the register bank while the CPU is       |
// | halted and drives index/value to the board display.                  |
// | Optional feature macro: REG_DUMP_SKIP_ZERO_EN (skip zero registers)  |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module reg_dump_sequencer
  import reg_dump_pkg::*;
#(
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int NUM_REGS     = 32,
  parameter int DATA_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hlt,
  input  logic                 step,
  input  logic [REG_IDX_W-1:0] cpuReadAddress1,
  input  logic [DATA_W-1:0]    data1,
  output logic [REG_IDX_W-1:0] readAddress1,
  output logic                 dumpActive,
  output logic [REG_IDX_W-1:0] dispIndex,
  output logic [DATA_W-1:0]    dispValue,
  output logic [6:0]           segIdxHi,
  output logic [6:0]           segIdxLo,
  output logic                 lapDone
);

  localparam int                   CNT_W    = $clog2(DWELL_CYCLES);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [REG_IDX_W-1:0] IDX_LAST = REG_IDX_W'(NUM_REGS - 1);

  dump_state_t          state;
  logic [REG_IDX_W-1:0] dump_idx;
  logic [CNT_W-1:0]     dwell_cnt;
  logic [REG_IDX_W-1:0] idx_next;
  logic                 idx_wrap;
  logic                 skip_now;

  assign idx_wrap     = (dump_idx == IDX_LAST);
  assign idx_next     = idx_wrap ? '0 : dump_idx + REG_IDX_W'(1);
  assign readAddress1 = (state == IDLE) ? cpuReadAddress1 : dump_idx;
  assign dumpActive   = (state != IDLE);

`ifdef REG_DUMP_SKIP_ZERO_EN
  localparam int SKIP_W = $clog2(NUM_REGS + 1);

  logic [SKIP_W-1:0] skip_cnt;

  // A full lap of zeros forces a capture so an all-zero bank still displays
  assign skip_now = (data1 == '0) && (skip_cnt != SKIP_W'(NUM_REGS));

  always_ff @(posedge clk) begin
    if (rst || state != ADDR || !hlt || !skip_now) begin
      skip_cnt <= '0;
    end else begin
      skip_cnt <= skip_cnt + SKIP_W'(1);
    end
  end
`else
  assign skip_now = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dump_idx  <= '0;
      dwell_cnt <= '0;
      dispIndex <= '0;
      dispValue <= '0;
      lapDone   <= 1'b0;
    end else if (state != IDLE && !hlt) begin
      // Leaving the halt overrides any pending step or dwell expiry
      state     <= IDLE;
      dump_idx  <= '0;
      dwell_cnt <= '0;
      dispIndex <= '0;
      dispValue <= '0;
      lapDone   <= 1'b0;
    end else begin
      lapDone <= 1'b0;
      case (state)
        IDLE: begin
          if (hlt) begin
            state    <= ADDR;
            dump_idx <= '0;
          end
        end
        ADDR: begin
          if (skip_now) begin
            dump_idx <= idx_next;
            lapDone  <= idx_wrap;
          end else begin
            dispValue <= data1;
            dispIndex <= dump_idx;
            dwell_cnt <= '0;
            state     <= SHOW;
          end
        end
        SHOW: begin
          if (step || dwell_cnt == CNT_LAST) begin
            dump_idx  <= idx_next;
            lapDone   <= idx_wrap;
            dwell_cnt <= '0;
            state     <= ADDR;
          end else begin
            dwell_cnt <= dwell_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  hex_to_seg7 u_seg_hi (
    .hex ({3'b000, dispIndex[4]}),
    .seg (segIdxHi)
  );

  hex_to_seg7 u_seg_lo (
    .hex (dispIndex[3:0]),
    .seg (segIdxLo)
  );

endmodule

`default_nettype wire

// File: tb/tb_reg_dump_sequencer.sv
// +----------------------------------------------------------------------+
// | tb_reg_dump_sequencer : scoreboard bench for reg_dump_sequencer      |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_reg_dump_sequencer;

  localparam int DWELL = 4;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] val;
    int          cyc;
  } cap_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hlt = 1'b1;
  logic        step = 1'b0;
  logic [4:0]  cpuReadAddress1 = 5'd7;
  logic [31:0] data1;
  logic [4:0]  readAddress1;
  logic        dumpActive;
  logic [4:0]  dispIndex;
  logic [31:0] dispValue;
  logic [6:0]  segIdxHi;
  logic [6:0]  segIdxLo;
  logic        lapDone;

  logic [31:0] rb [32];
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  cap_t        cap_q[$];
  int          lap_q[$];
  logic [4:0]  prev_idx = '0;
  logic [31:0] prev_val = '0;

  reg_dump_sequencer #(
    .DWELL_CYCLES (DWELL),
    .NUM_REGS     (32),
    .DATA_W       (32)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .hlt             (hlt),
    .step            (step),
    .cpuReadAddress1 (cpuReadAddress1),
    .data1           (data1),
    .readAddress1    (readAddress1),
    .dumpActive      (dumpActive),
    .dispIndex       (dispIndex),
    .dispValue       (dispValue),
    .segIdxHi        (segIdxHi),
    .segIdxLo        (segIdxLo),
    .lapDone         (lapDone)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign data1 = rb[readAddress1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_caps(input int first, input int c0, input int n);
    cap_t e;
    for (int i = 0; i < n; i++) begin
      e.idx = 5'((first + i) % 32);
      e.val = rb[(first + i) % 32];
      e.cyc = c0 + 5 * i;
      cap_q.push_back(e);
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Monitor: a change of the displayed pair while dumping is a capture event
  always @(negedge clk) begin
    cap_t e;
    int   lc;
    if (!rst) begin
      if (dumpActive && {dispIndex, dispValue} !== {prev_idx, prev_val}) begin
        if (cap_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_capture: got idx %0d val %0h, expected no capture (cycle %0d)",
                   dispIndex, dispValue, cyc);
        end else begin
          e = cap_q.pop_front();
          check("cap_idx", 64'(dispIndex), 64'(e.idx));
          check("cap_val", 64'(dispValue), 64'(e.val));
          check("cap_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
      if (lapDone) begin
        if (lap_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_lapDone: got 1, expected 0 (cycle %0d)", cyc);
        end else begin
          lc = lap_q.pop_front();
          check("lap_cycle", 64'(cyc), 64'(lc));
        end
      end
    end
    prev_idx = dispIndex;
    prev_val = dispValue;
  end

  initial begin
    int k0;
    int k1;
`ifdef REG_DUMP_SKIP_ZERO_EN
    int k2;
    int k3;
`endif
    for (int n = 0; n < 32; n++) rb[n] = 32'(n * 16 + 1);

    repeat (2) @(negedge clk);
    check("rst_dispIndex", 64'(dispIndex), 64'd0);
    check("rst_dispValue", 64'(dispValue), 64'd0);
    check("rst_lapDone", 64'(lapDone), 64'd0);
    check("rst_dumpActive", 64'(dumpActive), 64'd0);
    check("rst_segHi", 64'(segIdxHi), 64'h40);
    check("rst_segLo", 64'(segIdxLo), 64'h40);
    check("rst_readAddr", 64'(readAddress1), 64'd7);

    // Sweep: full lap plus start of the second lap
    rst = 1'b0;
    k0  = cyc;
    push_caps(0, k0 + 2, 32);
    lap_q.push_back(k0 + 161);
    push_caps(0, k0 + 162, 4);

    wait_until(k0 + 157);
    check("seg_hi_idx31", 64'(segIdxHi), 64'h79);
    check("seg_lo_idx31", 64'(segIdxLo), 64'h0E);

    // Early step at idx 3 with counter 1
    wait_until(k0 + 178);
    step = 1'b1;
    push_caps(4, k0 + 180, 1);
    @(negedge clk);
    step = 1'b0;
    push_caps(5, k0 + 185, 6);

    // Step coincides with dwell expiry at idx 5
    wait_until(k0 + 188);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;

    wait_until(k0 + 211);
    check("show_dumpActive", 64'(dumpActive), 64'd1);
    check("show_readAddr", 64'(readAddress1), 64'd10);
    check("seg_hi_idx10", 64'(segIdxHi), 64'h40);
    check("seg_lo_idx10", 64'(segIdxLo), 64'h08);
    hlt             = 1'b0;
    cpuReadAddress1 = 5'd9;
    @(negedge clk);
    check("drop_dumpActive", 64'(dumpActive), 64'd0);
    check("drop_dispValue", 64'(dispValue), 64'd0);
    check("drop_dispIndex", 64'(dispIndex), 64'd0);
    check("drop_readAddr", 64'(readAddress1), 64'd9);

    // step while idle is ignored
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
    check("idle_step_dumpActive", 64'(dumpActive), 64'd0);
    check("idle_step_dispIndex", 64'(dispIndex), 64'd0);

    // Restart then reset mid-dump
    k1  = cyc;
    hlt = 1'b1;
    push_caps(0, k1 + 2, 2);
    wait_until(k1 + 9);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_dumpActive", 64'(dumpActive), 64'd0);
    check("midrst_dispIndex", 64'(dispIndex), 64'd0);
    check("midrst_dispValue", 64'(dispValue), 64'd0);
    check("midrst_readAddr", 64'(readAddress1), 64'd9);
    rst = 1'b0;
    hlt = 1'b0;
    @(negedge clk);

`ifdef REG_DUMP_SKIP_ZERO_EN
    for (int n = 2; n <= 5; n++) rb[n] = 32'd0;
    k2  = cyc;
    hlt = 1'b1;
    push_caps(0, k2 + 2, 2);
    push_caps(6, k2 + 16, 1);
    wait_until(k2 + 18);
    hlt = 1'b0;
    repeat (2) @(negedge clk);

    for (int n = 0; n < 32; n++) rb[n] = 32'd0;
    k3  = cyc;
    hlt = 1'b1;
    lap_q.push_back(k3 + 33);
    wait_until(k3 + 20);
    check("skip_readAddr19", 64'(readAddress1), 64'd19);
    wait_until(k3 + 34);
    check("allzero_dispIndex", 64'(dispIndex), 64'd0);
    check("allzero_readAddr", 64'(readAddress1), 64'd0);
    @(negedge clk);
    check("allzero_show_readAddr", 64'(readAddress1), 64'd0);
    hlt = 1'b0;
    repeat (2) @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    check("cap_queue_empty", 64'(cap_q.size()), 64'd0);
    check("lap_queue_empty", 64'(lap_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
